// File: rtl/fmul_round_stage.sv
`default_nettype none
// ============================================================================
// Module : fmul_round_stage
// Rounds a normalised multiplier significand to MAN_W bits (five rounding
// modes) through a two-stage valid/ready pipeline.
// Rev    : 1.0
// ============================================================================

module fmul_round_stage #(
  parameter int SIG_W   = 64,
  parameter int MAN_W   = 24,
  parameter int LSB_POS = 24,
  parameter int EXP_W   = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SIG_W:0]   x_i,
  input  logic [EXP_W-1:0] e_i,
  input  logic [2:0]       rm_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [SIG_W:0]   x_o,
  output logic [EXP_W-1:0] e_o,
  output logic             inexact_o,
  output logic             ovf_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int c_hi_w = SIG_W - LSB_POS - MAN_W;

  localparam logic [2:0] c_rm_rne = 3'd0;
  localparam logic [2:0] c_rm_rtz = 3'd1;
  localparam logic [2:0] c_rm_rdn = 3'd2;
  localparam logic [2:0] c_rm_rup = 3'd3;
  localparam logic [2:0] c_rm_rhu = 3'd4;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic w_s2_accept;
  logic w_in_fire;
  logic w_s2_load;

  assign w_s2_accept = !s2_valid_q || out_ready_i;
  assign in_ready_o  = !s1_valid_q || w_s2_accept;
  assign w_in_fire   = in_valid_i && in_ready_o;
  assign w_s2_load   = w_s2_accept && s1_valid_q;

  // S1 drains into S2 whenever S2 accepts, so a full S1 refills in that cycle.
  assign s1_valid_d  = w_in_fire || (s1_valid_q && !w_s2_accept);
  assign s2_valid_d  = w_s2_accept ? s1_valid_q : s2_valid_q;

  // --------------------------------------------------------------------------
  // Stage 1: field extraction and round decision
  // --------------------------------------------------------------------------
  logic             w_sign;
  logic [MAN_W-1:0] w_man;
  logic             w_l, w_g, w_s;
  logic             w_inc;
  logic             w_unused_hi;

  assign w_sign      = x_i[SIG_W];
  assign w_man       = x_i[LSB_POS+MAN_W-1:LSB_POS];
  assign w_l         = x_i[LSB_POS];
  assign w_g         = x_i[LSB_POS-1];
  assign w_s         = |x_i[LSB_POS-2:0];
  assign w_unused_hi = ^x_i[SIG_W-1:LSB_POS+MAN_W];

  always_comb begin
    w_inc = 1'b0;
    case (rm_i)
      c_rm_rtz: w_inc = 1'b0;
      c_rm_rdn: w_inc = w_sign && (w_g || w_s);
      c_rm_rup: w_inc = !w_sign && (w_g || w_s);
      c_rm_rhu: w_inc = w_g;
      c_rm_rne: w_inc = w_g && (w_l || w_s);
      default:  w_inc = w_g && (w_l || w_s);
    endcase
  end

  logic             s1_sign_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MAN_W-1:0] s1_man_q;
  logic             s1_g_q, s1_s_q;
  logic             s1_inc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_man_q   <= '0;
      s1_g_q     <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_inc_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (w_in_fire) begin
        s1_sign_q <= w_sign;
        s1_exp_q  <= e_i;
        s1_man_q  <= w_man;
        s1_g_q    <= w_g;
        s1_s_q    <= w_s;
        s1_inc_q  <= w_inc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: increment, renormalise on carry-out, saturate exponent
  // --------------------------------------------------------------------------
  logic [MAN_W:0]   w_sum;
  logic             w_carry;
  logic             w_exp_max;
  logic [MAN_W-1:0] s2_man_d;
  logic [EXP_W-1:0] s2_exp_d;
  logic             s2_ovf_d;

  assign w_sum     = {1'b0, s1_man_q} + {{MAN_W{1'b0}}, s1_inc_q};
  assign w_carry   = w_sum[MAN_W];
  assign w_exp_max = &s1_exp_q;

  always_comb begin
    s2_man_d = w_sum[MAN_W-1:0];
    s2_exp_d = s1_exp_q;
    s2_ovf_d = 1'b0;
    if (w_carry) begin
      // Carry out of an all-ones mantissa always leaves exactly 1.000...
      s2_man_d = {1'b1, {(MAN_W-1){1'b0}}};
      if (w_exp_max) begin
        s2_ovf_d = 1'b1;
      end else begin
        s2_exp_d = s1_exp_q + {{(EXP_W-1){1'b0}}, 1'b1};
      end
    end
  end

  logic             s2_sign_q;
  logic [MAN_W-1:0] s2_man_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic             s2_inx_q;
  logic             s2_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_man_q   <= '0;
      s2_exp_q   <= '0;
      s2_inx_q   <= 1'b0;
      s2_ovf_q   <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (w_s2_load) begin
        s2_sign_q <= s1_sign_q;
        s2_man_q  <= s2_man_d;
        s2_exp_q  <= s2_exp_d;
        s2_inx_q  <= s1_g_q || s1_s_q;
        s2_ovf_q  <= s2_ovf_d;
      end
    end
  end

  assign out_valid_o = s2_valid_q;
  assign x_o         = {s2_sign_q, {c_hi_w{1'b0}}, s2_man_q, {LSB_POS{1'b0}}};
  assign e_o         = s2_exp_q;
  assign inexact_o   = s2_inx_q;
  assign ovf_o       = s2_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_fmul_round_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_fmul_round_stage
// Directed and randomised checks of fmul_round_stage against a numeric model.
// Rev    : 1.0
// ============================================================================

module tb_fmul_round_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [64:0] x_i = '0;
  logic [8:0]  e_i = '0;
  logic [2:0]  rm_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [64:0] x_o;
  logic [8:0]  e_o;
  logic        inexact_o;
  logic        ovf_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;

  fmul_round_stage #(.SIG_W(64), .MAN_W(24), .LSB_POS(24), .EXP_W(9)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x_i         (x_i),
    .e_i         (e_i),
    .rm_i        (rm_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .x_o         (x_o),
    .e_o         (e_o),
    .inexact_o   (inexact_o),
    .ovf_o       (ovf_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [64:0] x;
    logic [8:0]  e;
    logic        inx;
    logic        ovf;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  logic in_fire_l;
  int   n_out;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Rounding expressed as a comparison of the discarded tail against one half.
  function automatic exp_t model(input logic [64:0] x, input logic [8:0] e, input logic [2:0] rm);
    exp_t r;
    longint unsigned sig  = x[63:0];
    longint unsigned man  = (sig >> 24) & 64'hFF_FFFF;
    longint unsigned rem  = sig & 64'hFF_FFFF;
    longint unsigned half = 64'h80_0000;
    logic s = x[64];
    logic up;
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = s && (rem != 0);
      3'd3:    up = !s && (rem != 0);
      3'd4:    up = (rem >= half);
      default: up = (rem > half) || (rem == half && (man & 1) == 1);
    endcase
    man   = man + (up ? 1 : 0);
    r.e   = e;
    r.ovf = 1'b0;
    if (man == 64'h100_0000) begin
      man = 64'h80_0000;
      if (e == 9'h1FF) r.ovf = 1'b1;
      else r.e = e + 9'd1;
    end
    r.x   = {s, 64'(man << 24)};
    r.inx = (rem != 0);
    return r;
  endfunction

  task automatic rand_beat(input int k);
    logic [63:0] sig;
    sig = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: sig = '0;
      1: sig[47:24] = 24'hFF_FFFF;
      2: sig[23:0]  = 24'h80_0000;
      default: ;
    endcase
    if (sig != 0) sig[47] = 1'b1;
    if (k >= 0) sig[27:24] = k[3:0];
    x_i  = {1'($urandom), sig};
    e_i  = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom);
    rm_i = 3'($urandom);
  endtask

  // One clock: observe at the falling edge, update the scoreboard, advance.
  task automatic step();
    logic inf, outf;
    @(negedge clk);
    inf  = in_valid_i && in_ready_o;
    outf = out_valid_o && out_ready_i;
    if (out_valid_o) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", {127'b0, out_valid_o}, 128'd0);
      end else begin
        check_eq("x_o", x_o, sb[0].x);
        check_eq("e_o", e_o, sb[0].e);
        check_eq("inexact_o", inexact_o, sb[0].inx);
        check_eq("ovf_o", ovf_o, sb[0].ovf);
      end
    end
    if (outf && sb.size() > 0) begin
      void'(sb.pop_front());
      n_out++;
    end
    if (inf) sb.push_back(model(x_i, e_i, rm_i));
    in_fire_l = inf;
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [64:0] x, input logic [8:0] e,
                          input logic [2:0] rm, input logic [64:0] ex, input logic [8:0] ee,
                          input logic ei, input logic eo);
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    x_i = x;
    e_i = e;
    rm_i = rm;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "_valid"}, out_valid_o, 1'b1);
    check_eq({tag, "_x"}, x_o, ex);
    check_eq({tag, "_e"}, e_o, ee);
    check_eq({tag, "_inx"}, inexact_o, ei);
    check_eq({tag, "_ovf"}, ovf_o, eo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    #12;
    check_eq("rst_valid", out_valid_o, 1'b0);
    check_eq("rst_x", x_o, 65'd0);
    check_eq("rst_e", e_o, 9'd0);
    check_eq("rst_inx", inexact_o, 1'b0);
    check_eq("rst_ovf", ovf_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rdy_after_rst", in_ready_o, 1'b1);
    @(posedge clk);
    #1;

    directed("rne_carry", 65'h0_0000FFFFFF800000, 9'h07F, 3'd0, 65'h0_0000800000000000, 9'h080, 1'b1, 1'b0);
    directed("rne_tie",   65'h0_0000800000800000, 9'h07F, 3'd0, 65'h0_0000800000000000, 9'h07F, 1'b1, 1'b0);
    directed("rhu_tie",   65'h0_0000800000800000, 9'h07F, 3'd4, 65'h0_0000800001000000, 9'h07F, 1'b1, 1'b0);
    directed("rm7_tie",   65'h0_0000800000800000, 9'h07F, 3'd7, 65'h0_0000800000000000, 9'h07F, 1'b1, 1'b0);
    directed("rtz_neg",   65'h1_0000800000000001, 9'h07F, 3'd1, 65'h1_0000800000000000, 9'h07F, 1'b1, 1'b0);
    directed("rdn_neg",   65'h1_0000800000000001, 9'h07F, 3'd2, 65'h1_0000800001000000, 9'h07F, 1'b1, 1'b0);
    directed("rup_neg",   65'h1_0000800000000001, 9'h07F, 3'd3, 65'h1_0000800000000000, 9'h07F, 1'b1, 1'b0);
    directed("ovf_sat",   65'h0_0000FFFFFFFFFFFF, 9'h1FF, 3'd3, 65'h0_0000800000000000, 9'h1FF, 1'b1, 1'b1);
    directed("exp_1fe",   65'h0_0000FFFFFF800000, 9'h1FE, 3'd0, 65'h0_0000800000000000, 9'h1FF, 1'b1, 1'b0);
    directed("zero_sig",  65'h1_0000000000000000, 9'h055, 3'd3, 65'h1_0000000000000000, 9'h055, 1'b0, 1'b0);
    directed("hi_clear",  65'h0_ABCD800000000000, 9'h010, 3'd0, 65'h0_0000800000000000, 9'h010, 1'b0, 1'b0);

    // Backpressure: four back-to-back beats with the sink stalled.
    sb.delete();
    n_out = 0;
    out_ready_i = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      if (k < 4) begin
        in_valid_i = 1'b1;
        rand_beat(k);
      end else begin
        in_valid_i = 1'b0;
      end
      step();
      if (in_fire_l) k++;
    end
    check_eq("bp_accepted", k, 2);
    check_eq("bp_in_ready", in_ready_o, 1'b0);
    out_ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (k < 4) begin
        in_valid_i = 1'b1;
        rand_beat(k);
      end else begin
        in_valid_i = 1'b0;
      end
      step();
      if (in_fire_l) k++;
    end
    check_eq("bp_drained", n_out, 4);
    check_eq("bp_sb_empty", sb.size(), 0);

    // Asynchronous reset with two beats in flight.
    out_ready_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid_i = 1'b1;
      rand_beat(c);
      step();
    end
    in_valid_i = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", out_valid_o, 1'b0);
    check_eq("arst_x", x_o, 65'd0);
    check_eq("arst_e", e_o, 9'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("stale_beat", out_valid_o, 1'b0);
    end
    @(posedge clk);
    #1;

    // Random traffic with random stalls on both sides.
    n_out = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid_i  = ($urandom_range(0, 9) < 7);
      out_ready_i = ($urandom_range(0, 9) < 6);
      rand_beat(-1);
      step();
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) step();
    check_eq("rand_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
